// File: rtl/dsm_capture.sv
// dsm_capture: one-shot capture buffer for internal DSM modulator samples.
// The block is armed, records SAMPLES entries from dsm_in/dsm_valid, drains
// them in index order through a valid/ready read port, then returns to idle.
// Optional trigger: define DSM_TRIGGER_EN to wait for dsm_in == trig_pattern
// before capture starts (the matching sample becomes entry 0).
module dsm_capture #(
   parameter int MOD_BITS = 4,
   parameter int SAMPLES  = 16
) (
   input  logic                         internal_clk,
   input  logic                         internal_rst_n,
   input  logic [MOD_BITS-1:0]          dsm_in,
   input  logic                         dsm_valid,
   input  logic                         arm,
   input  logic                         abort,
   input  logic [MOD_BITS-1:0]          trig_pattern,
   output logic [MOD_BITS-1:0]          rd_data,
   output logic                         rd_valid,
   input  logic                         rd_ready,
   output logic                         rd_last,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(SAMPLES+1)-1:0] count
);

   localparam int PTR_W = $clog2(SAMPLES);
   localparam int CNT_W = $clog2(SAMPLES + 1);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(SAMPLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
`ifdef DSM_TRIGGER_EN
      ARMED   = 2'd1,
`endif
      CAPTURE = 2'd2,
      READOUT = 2'd3
   } state_t;

   state_t               state, next_state;
   logic [MOD_BITS-1:0]  mem [SAMPLES];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr, next_rd;
   logic                 clr, wr_en, enter_rd, xfer;

`ifndef DSM_TRIGGER_EN
   // The trigger value is only consumed when the trigger option is built.
   logic unused_trig;
   assign unused_trig = ^trig_pattern;
`endif

   assign busy    = (state != IDLE);
   assign next_rd = rd_ptr + 1'b1;

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge internal_clk) begin
      if (!internal_rst_n) state <= IDLE;
      else                 state <= next_state;
   end

   // Next-state decode plus datapath strobes; abort overrides everything.
   // NOTE: every output gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state;
      clr        = 1'b0;
      wr_en      = 1'b0;
      enter_rd   = 1'b0;
      xfer       = 1'b0;
      if (abort) begin
         next_state = IDLE;
         clr        = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (arm) begin
                  clr = 1'b1;
`ifdef DSM_TRIGGER_EN
                  next_state = ARMED;
`else
                  next_state = CAPTURE;
`endif
               end
            end
`ifdef DSM_TRIGGER_EN
            ARMED: begin
               if (dsm_valid && (dsm_in == trig_pattern)) begin
                  wr_en      = 1'b1;
                  next_state = CAPTURE;
               end
            end
`endif
            CAPTURE: begin
               if (dsm_valid) begin
                  wr_en = 1'b1;
                  if (wr_ptr == LAST_IDX) begin
                     enter_rd   = 1'b1;
                     next_state = READOUT;
                  end
               end
            end
            READOUT: begin
               if (rd_valid && rd_ready) begin
                  xfer = 1'b1;
                  if (rd_last) next_state = IDLE;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // Sample storage write port.
   // NOTE: the buffer is deliberately not reset; contents are don't-care until written.
   always_ff @(posedge internal_clk) begin
      if (wr_en) mem[wr_ptr] <= dsm_in;
   end

   // Pointers, fill count and the registered read port.
   always_ff @(posedge internal_clk) begin
      if (!internal_rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
         end else begin
            if (wr_en) begin
               // Hold at the last index; the buffer never wraps.
               if (wr_ptr != LAST_IDX) wr_ptr <= wr_ptr + 1'b1;
               count <= count + CNT_W'(1);
            end
            if (enter_rd) begin
               // Entry 0 was written on an earlier edge (SAMPLES >= 2).
               rd_valid <= 1'b1;
               rd_data  <= mem[0];
               rd_last  <= 1'b0;
            end
            if (xfer) begin
               count <= count - CNT_W'(1);
               if (rd_last) begin
                  rd_valid <= 1'b0;
                  rd_last  <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  rd_ptr  <= next_rd;
                  rd_data <= mem[next_rd];
                  rd_last <= (next_rd == LAST_IDX);
               end
            end
         end
      end
   end

endmodule
